issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; equals the WIDTH of the downstream grant arbiter.
REQ-002 Parameter TAGW, default 6, physical-register tag width.
REQ-003 Parameter DATAW, default 32, opaque micro-op payload width.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_flush  input  1  synchronous clear of all entries.
REQ-007 i_disp_valid  input  1  dispatch request.
REQ-008 o_disp_ready  output  1  queue can accept a dispatch this cycle.
REQ-009 i_disp_data  input  DATAW  micro-op payload.
REQ-010 i_disp_rs1 / i_disp_rs2  input  TAGW each  source tags.
REQ-011 i_disp_rs1_rdy / i_disp_rs2_rdy  input  1 each  source already available.
REQ-012 i_wb_valid  input  1  wakeup broadcast valid.
REQ-013 i_wb_tag  input  TAGW  tag being woken.
REQ-014 o_request  output  DEPTH  per-entry issue request to the arbiter.
REQ-015 i_grant  input  DEPTH  one-hot grant returned by the arbiter.
REQ-016 i_issue_en  input  1  downstream execution unit accepts an op this cycle.
REQ-017 o_issue_valid  output  1  registered issued-op valid.
REQ-018 o_issue_data  output  DATAW  registered issued-op payload.
REQ-019 o_count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 Each entry SHALL hold valid, payload, rs1/rs2 tags and rs1/rs2 ready bits.
REQ-021 o_request[k] SHALL equal valid[k] & rdy1[k] & rdy2[k], combinational from registered state only.
REQ-022 o_disp_ready SHALL be 1 iff at least one entry is invalid (based on current registered state).
REQ-023 Dispatch (i_disp_valid & o_disp_ready) SHALL write the lowest-index invalid entry, valid=1 next cycle.
REQ-024 Dispatch while o_disp_ready=0 SHALL be ignored, no state change.
REQ-025 Wakeup: when i_wb_valid, every valid entry with rsN == i_wb_tag SHALL set rdyN=1 next cycle; both sources may wake in one cycle.
REQ-026 Dispatch bypass: a dispatched source whose tag equals i_wb_tag while i_wb_valid SHALL be written ready.
REQ-027 Issue: when i_issue_en and i_grant[k] & o_request[k], entry k SHALL be invalidated and o_issue_valid=1, o_issue_data=payload[k] on the next cycle (latency 1).
REQ-028 If i_grant has multiple bits set, only the lowest set bit SHALL be honoured.
REQ-029 Grant to a non-requesting entry, grant=0, or i_issue_en=0 SHALL issue nothing; o_issue_valid=0 next cycle.
REQ-030 A slot freed by issue SHALL NOT be re-allocated in the same cycle; dispatch and issue in one cycle SHALL both proceed on distinct slots.
REQ-031 o_count SHALL update next cycle by +1 on dispatch, -1 on issue, net 0 on both.
REQ-032 i_flush SHALL override dispatch, issue and wakeup: all valid=0, o_issue_valid=0, o_count=0 next cycle.

Reset
REQ-033 On i_rst_n=0, immediately and regardless of clock: all valid=0, all ready bits=0, o_issue_valid=0, o_issue_data=0, o_count=0; hence o_request=0, o_disp_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all entries and any in-flight issue; first dispatch after release SHALL go to entry 0.

Verification
REQ-035 Dispatch 8 ops with both rdy=1, no grants -> entries 0..7 valid, o_count=8, o_disp_ready=0, o_request=8'hFF; 9th dispatch ignored.
REQ-036 Dispatch op rs1=5 rdy=0, rs2 rdy=1 into empty queue -> o_request=0; pulse i_wb_valid, i_wb_tag=5 -> next cycle o_request=8'h01.
REQ-037 Same-cycle dispatch rs1=9 rdy=0 with i_wb_valid, i_wb_tag=9 -> entry written ready, o_request[0]=1 next cycle.
REQ-038 Full queue, i_grant=8'h04, i_issue_en=1, simultaneous dispatch -> dispatch ignored (was full), next cycle o_issue_valid=1 with entry-2 payload, o_count=7; following dispatch fills entry 2.
REQ-039 Entries 0..3 valid, i_flush=1 with i_disp_valid=1 and i_grant=8'h01 -> next cycle o_count=0, o_issue_valid=0, o_request=0.
REQ-040 Assert i_rst_n=0 between clock edges with 3 valid entries -> outputs cleared before next edge; after release, dispatch lands in entry 0.

Source files
------------

// File: rtl/issue_queue.sv
// Issue queue: holds dispatched micro-ops until both source operands are ready,
// raises per-entry requests to an external arbiter and issues the granted op with one cycle of latency.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 6,
  parameter int DATAW = 32,
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_disp_valid,
  output logic             o_disp_ready,
  input  logic [DATAW-1:0] i_disp_data,
  input  logic [TAGW-1:0]  i_disp_rs1,
  input  logic [TAGW-1:0]  i_disp_rs2,
  input  logic             i_disp_rs1_rdy,
  input  logic             i_disp_rs2_rdy,
  input  logic             i_wb_valid,
  input  logic [TAGW-1:0]  i_wb_tag,
  output logic [DEPTH-1:0] o_request,
  input  logic [DEPTH-1:0] i_grant,
  input  logic             i_issue_en,
  output logic             o_issue_valid,
  output logic [DATAW-1:0] o_issue_data,
  output logic [CNTW-1:0]  o_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  logic [TAGW-1:0]  rs1_q [DEPTH];
  logic [TAGW-1:0]  rs2_q [DEPTH];
  logic [DATAW-1:0] data_q [DEPTH];
  logic             issue_valid_q, issue_valid_d;
  logic [DATAW-1:0] issue_data_q, issue_data_d;
  logic [CNTW-1:0]  count_q, count_d;

  logic [DEPTH-1:0] req;
  logic [IDXW-1:0]  free_idx;
  logic [IDXW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             disp_fire;
  logic             issue_fire;

  assign req           = valid_q & rdy1_q & rdy2_q;
  assign o_request     = req;
  assign o_disp_ready  = ~(&valid_q);
  assign o_issue_valid = issue_valid_q;
  assign o_issue_data  = issue_data_q;
  assign o_count       = count_q;

  // Lowest free slot for dispatch and lowest grant bit for issue.
  always_comb begin
    free_idx = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!valid_q[k]) free_idx = IDXW'(k);
      if (i_grant[k]) begin
        gnt_idx = IDXW'(k);
        gnt_any = 1'b1;
      end
    end
  end

  // A granted slot is valid, so it can never coincide with the free slot.
  assign disp_fire  = i_disp_valid & o_disp_ready;
  assign issue_fire = i_issue_en & gnt_any & req[gnt_idx];

  always_comb begin
    valid_d       = valid_q;
    rdy1_d        = rdy1_q;
    rdy2_d        = rdy2_q;
    issue_valid_d = 1'b0;
    issue_data_d  = issue_data_q;
    count_d       = count_q;

    for (int k = 0; k < DEPTH; k++) begin
      if (i_wb_valid && valid_q[k] && (rs1_q[k] == i_wb_tag)) rdy1_d[k] = 1'b1;
      if (i_wb_valid && valid_q[k] && (rs2_q[k] == i_wb_tag)) rdy2_d[k] = 1'b1;
    end

    if (issue_fire) begin
      valid_d[gnt_idx] = 1'b0;
      issue_valid_d    = 1'b1;
      issue_data_d     = data_q[gnt_idx];
    end

    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = i_disp_rs1_rdy | (i_wb_valid && (i_disp_rs1 == i_wb_tag));
      rdy2_d[free_idx]  = i_disp_rs2_rdy | (i_wb_valid && (i_disp_rs2 == i_wb_tag));
    end

    case ({disp_fire, issue_fire})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    if (i_flush) begin
      valid_d       = '0;
      issue_valid_d = 1'b0;
      count_d       = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
      count_q       <= '0;
    end else begin
      valid_q       <= valid_d;
      rdy1_q        <= rdy1_d;
      rdy2_q        <= rdy2_d;
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
      count_q       <= count_d;
    end
  end

  // Payload and tags are qualified by valid, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (disp_fire && !i_flush) begin
      data_q[free_idx] <= i_disp_data;
      rs1_q[free_idx]  <= i_disp_rs1;
      rs2_q[free_idx]  <= i_disp_rs2;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: fill/full, wakeup, bypass, issue, multi-grant, flush and async reset.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int TAGW  = 6;
  localparam int DATAW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [DATAW-1:0] disp_data;
  logic [TAGW-1:0]  disp_rs1, disp_rs2;
  logic             disp_rs1_rdy, disp_rs2_rdy;
  logic             wb_valid;
  logic [TAGW-1:0]  wb_tag;
  logic [DEPTH-1:0] request;
  logic [DEPTH-1:0] grant;
  logic             issue_en;
  logic             issue_valid;
  logic [DATAW-1:0] issue_data;
  logic [3:0]       count;

  int n_cmp = 0;
  int n_bad = 0;

  issue_queue #(.DEPTH(DEPTH), .TAGW(TAGW), .DATAW(DATAW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_disp_valid   (disp_valid),
    .o_disp_ready   (disp_ready),
    .i_disp_data    (disp_data),
    .i_disp_rs1     (disp_rs1),
    .i_disp_rs2     (disp_rs2),
    .i_disp_rs1_rdy (disp_rs1_rdy),
    .i_disp_rs2_rdy (disp_rs2_rdy),
    .i_wb_valid     (wb_valid),
    .i_wb_tag       (wb_tag),
    .o_request      (request),
    .i_grant        (grant),
    .i_issue_en     (issue_en),
    .o_issue_valid  (issue_valid),
    .o_issue_data   (issue_data),
    .o_count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_data = '0; disp_rs1 = '0; disp_rs2 = '0;
    disp_rs1_rdy = 0; disp_rs2_rdy = 0; wb_valid = 0; wb_tag = '0;
    grant = '0; issue_en = 0;
  endtask

  task automatic set_disp(input logic [DATAW-1:0] d, input logic [TAGW-1:0] r1, input logic k1,
                          input logic [TAGW-1:0] r2, input logic k2);
    disp_valid = 1; disp_data = d; disp_rs1 = r1; disp_rs1_rdy = k1; disp_rs2 = r2; disp_rs2_rdy = k2;
  endtask

  initial begin
    rst_n = 0;
    idle();
    #12;
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_req", request, 0);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_idata", issue_data, 0);
    rst_n = 1;
    step();

    // Fill all 8 entries with ready ops
    for (int i = 0; i < 8; i++) begin
      set_disp(32'h100 + i, 6'd1, 1, 6'd2, 1);
      step();
    end
    idle();
    chk("full_count", count, 8);
    chk("full_ready", disp_ready, 0);
    chk("full_req", request, 8'hFF);
    set_disp(32'hDEAD, 6'd1, 1, 6'd2, 1);
    step();
    idle();
    chk("ninth_count", count, 8);

    // Issue entry 2 while a dispatch arrives at a full queue
    grant = 8'h04; issue_en = 1;
    set_disp(32'hBEEF, 6'd1, 1, 6'd2, 1);
    step();
    idle();
    chk("iss2_valid", issue_valid, 1);
    chk("iss2_data", issue_data, 32'h102);
    chk("iss2_count", count, 7);
    chk("iss2_req", request, 8'hFB);
    set_disp(32'h555, 6'd1, 1, 6'd2, 1);
    step();
    idle();
    chk("refill_ivalid", issue_valid, 0);
    chk("refill_count", count, 8);
    chk("refill_req", request, 8'hFF);
    grant = 8'h04; issue_en = 1;
    step();
    idle();
    chk("refill_data", issue_data, 32'h555);

    // Multiple grant bits: lowest (entry 1) wins
    grant = 8'h0A; issue_en = 1;
    step();
    idle();
    chk("multi_valid", issue_valid, 1);
    chk("multi_data", issue_data, 32'h101);
    chk("multi_count", count, 6);
    chk("multi_req", request, 8'hF9);

    grant = 8'h01; issue_en = 0;
    step();
    idle();
    chk("noen_valid", issue_valid, 0);
    chk("noen_count", count, 6);
    grant = 8'h04; issue_en = 1;
    step();
    idle();
    chk("noreq_valid", issue_valid, 0);
    chk("noreq_count", count, 6);

    // Flush overrides dispatch and issue
    flush = 1; grant = 8'h01; issue_en = 1;
    set_disp(32'h777, 6'd1, 1, 6'd2, 1);
    step();
    idle();
    chk("flush_count", count, 0);
    chk("flush_ivalid", issue_valid, 0);
    chk("flush_req", request, 0);
    chk("flush_ready", disp_ready, 1);

    // Wakeup of rs1
    set_disp(32'h36, 6'd5, 0, 6'd3, 1);
    step();
    idle();
    chk("wait_req", request, 0);
    chk("wait_count", count, 1);
    wb_valid = 1; wb_tag = 6'd6;
    step();
    idle();
    chk("wrongtag_req", request, 0);
    wb_valid = 1; wb_tag = 6'd5;
    step();
    idle();
    chk("wake_req", request, 8'h01);
    grant = 8'h01; issue_en = 1;
    step();
    idle();
    chk("wake_idata", issue_data, 32'h36);
    chk("wake_count", count, 0);

    // Both sources woken by the same broadcast
    set_disp(32'h77, 6'd7, 0, 6'd7, 0);
    step();
    idle();
    chk("both_wait", request, 0);
    wb_valid = 1; wb_tag = 6'd7;
    step();
    idle();
    chk("both_wake", request, 8'h01);
    flush = 1;
    step();
    idle();

    // Dispatch bypass from a same-cycle broadcast
    set_disp(32'h99, 6'd9, 0, 6'd4, 1);
    wb_valid = 1; wb_tag = 6'd9;
    step();
    idle();
    chk("bypass_req", request, 8'h01);

    // Async reset mid-operation with an issue in flight
    for (int i = 1; i < 4; i++) begin
      set_disp(32'h200 + i, 6'd1, 1, 6'd2, 1);
      step();
    end
    idle();
    chk("pre_rst_count", count, 4);
    grant = 8'h01; issue_en = 1;
    step();
    idle();
    chk("pre_rst_ivalid", issue_valid, 1);
    chk("pre_rst_idata", issue_data, 32'h99);
    chk("pre_rst_count3", count, 3);
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_ivalid", issue_valid, 0);
    chk("arst_idata", issue_data, 0);
    chk("arst_req", request, 0);
    chk("arst_ready", disp_ready, 1);
    #2;
    rst_n = 1;
    set_disp(32'h40, 6'd1, 1, 6'd2, 1);
    step();
    idle();
    chk("post_rst_req", request, 8'h01);
    chk("post_rst_count", count, 1);
    grant = 8'h01; issue_en = 1;
    step();
    idle();
    chk("post_rst_data", issue_data, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
